// File: rtl/mzf_loader.sv
// MZF tape-image loader: parses the 128-byte header from the ioctl stream and
// writes the body into main RAM through the arbiter's request/grant port.
module mzf_loader #(
    parameter int FIFO_AW = 2,
    parameter int HDR_LEN = 128
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ram_req,
    input  logic        ram_gnt,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        exec_start,
    output logic [1:0]  err_code,
    output logic [7:0]  file_type,
    output logic [15:0] file_size,
    output logic [15:0] load_addr,
    output logic [15:0] exec_addr
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IDX_W = $clog2(HDR_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_BODY, S_FINISH, S_DONE, S_ERROR} state_t;

    state_t               state_q, state_d;
    logic                 dl_q, dl_d;
    logic [7:0]           fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [15:0]          wptr_q, wptr_d, remaining_q, remaining_d;
    logic                 ram_req_q, ram_req_d;
    logic [15:0]          ram_addr_q, ram_addr_d;
    logic [7:0]           ram_wdata_q, ram_wdata_d;
    logic [1:0]           err_q, err_d;
    logic                 done_q, done_d, exec_q, exec_d;
    logic [7:0]           file_type_q, file_type_d;
    logic [15:0]          file_size_q, file_size_d, load_addr_q, load_addr_d;
    logic [15:0]          exec_addr_q, exec_addr_d;

    logic busy_w, rise, fifo_empty, fifo_full, push_req, push, pop, fifo_clr;
    logic [7:0] head;

    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        idx_d       = idx_q;
        wptr_d      = wptr_q;
        remaining_d = remaining_q;
        ram_req_d   = ram_req_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        err_d       = err_q;
        done_d      = 1'b0;
        exec_d      = 1'b0;
        file_type_d = file_type_q;
        file_size_d = file_size_q;
        load_addr_d = load_addr_q;
        exec_addr_d = exec_addr_q;
        pop         = 1'b0;
        fifo_clr    = 1'b0;

        busy_w     = (state_q == S_HEADER) || (state_q == S_BODY) || (state_q == S_FINISH);
        rise       = ioctl_download && !dl_q;
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
        head       = fifo_mem[rd_ptr_q];
        push_req   = ioctl_wr && busy_w;
        push       = push_req && !fifo_full;
        if (push_req && fifo_full) err_d = 2'd3;

        case (state_q)
            S_HEADER: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    idx_d = idx_q + 1'b1;
                    case (idx_q)
                        IDX_W'(8'h00): file_type_d       = head;
                        IDX_W'(8'h12): file_size_d[7:0]  = head;
                        IDX_W'(8'h13): file_size_d[15:8] = head;
                        IDX_W'(8'h14): load_addr_d[7:0]  = head;
                        IDX_W'(8'h15): load_addr_d[15:8] = head;
                        IDX_W'(8'h16): exec_addr_d[7:0]  = head;
                        IDX_W'(8'h17): exec_addr_d[15:8] = head;
                        default: ;
                    endcase
                    if (idx_q == IDX_LAST) begin
                        remaining_d = file_size_q;
                        wptr_d      = load_addr_q;
                        state_d     = (file_size_q == 16'd0) ? S_FINISH : S_BODY;
                    end
                end else if (!ioctl_download && !ioctl_wr) begin
                    if (err_q == 2'd0) err_d = 2'd1;
                    state_d = S_ERROR;
                end
            end
            S_BODY: begin
                if (ram_req_q) begin
                    if (ram_gnt) begin
                        wptr_d      = wptr_q + 16'd1;
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            ram_req_d = 1'b0;
                            state_d   = S_FINISH;
                        end else if (!fifo_empty) begin
                            // Back-to-back: stage the next byte at the post-increment address.
                            pop         = 1'b1;
                            ram_wdata_d = head;
                            ram_addr_d  = wptr_q + 16'd1;
                        end else begin
                            ram_req_d = 1'b0;
                        end
                    end
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    ram_wdata_d = head;
                    ram_addr_d  = wptr_q;
                    ram_req_d   = 1'b1;
                end else if (!ioctl_download && !ioctl_wr) begin
                    if (err_q == 2'd0) err_d = 2'd2;
                    state_d = S_ERROR;
                end
            end
            S_FINISH: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else if (!ioctl_download && !ioctl_wr) begin
                    if (err_q != 2'd0) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        exec_d  = (file_type_q == 8'h01);
                    end
                end
            end
            default: begin
                // IDLE, DONE, ERROR: only a fresh download rising edge restarts.
                if (rise) begin
                    state_d     = S_HEADER;
                    fifo_clr    = 1'b1;
                    idx_d       = '0;
                    err_d       = 2'd0;
                    file_type_d = 8'h00;
                    file_size_d = 16'h0000;
                    load_addr_d = 16'h0000;
                    exec_addr_d = 16'h0000;
                end
            end
        endcase

        if (fifo_clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
            wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
            cnt_d    = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr_q] <= ioctl_dout;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dl_q        <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            wptr_q      <= 16'h0000;
            remaining_q <= 16'h0000;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 8'h00;
            err_q       <= 2'd0;
            done_q      <= 1'b0;
            exec_q      <= 1'b0;
            file_type_q <= 8'h00;
            file_size_q <= 16'h0000;
            load_addr_q <= 16'h0000;
            exec_addr_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wptr_q      <= wptr_d;
            remaining_q <= remaining_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
            exec_q      <= exec_d;
            file_type_q <= file_type_d;
            file_size_q <= file_size_d;
            load_addr_q <= load_addr_d;
            exec_addr_q <= exec_addr_d;
        end
    end

    assign ram_req    = ram_req_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = busy_w;
    assign cpu_hold   = busy_w;
    assign done       = done_q;
    assign exec_start = exec_q;
    assign err_code   = err_q;
    assign file_type  = file_type_q;
    assign file_size  = file_size_q;
    assign load_addr  = load_addr_q;
    assign exec_addr  = exec_addr_q;
endmodule
